mem_access_tracer: RTL and testbench

Passive bus tracer on the DA_VINCI memory interface, between the CPU's ADDR/MEM_DATA_IN/READ/WRITE outputs and the memory model. Snoops every write transaction inside an address window and records {address, data, timestamp} in a FIFO. A consumer drains the FIFO over a valid/ready dump port. It lets the testbench check program stores (Fibonacci, RevFib) cycle by cycle instead of relying only on end-of-run memory dumps. The tracer never drives the memory bus.

---
 rtl/mem_access_tracer_pkg.sv | 18 +
 rtl/prj_definition.v | 10 +
 rtl/trace_fifo.sv | 94 +++++++++
 rtl/mem_access_tracer.sv | 114 +++++++++++
 tb/tb_mem_access_tracer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_tracer_pkg.sv
// rtl/mem_access_tracer_pkg.sv - widths and helpers shared by the memory access tracer
`include "prj_definition.v"

package mem_access_tracer_pkg;

  localparam int ADDR_W = `ADDRESS_INDEX_LIMIT + 1;
  localparam int DATA_W = `DATA_INDEX_LIMIT + 1;
  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

  // Inclusive unsigned window test; taking bounds as arguments keeps a zero lower bound from folding away.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] lo,
                                     input logic [ADDR_W-1:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/prj_definition.v
// rtl/prj_definition.v - shared width and trace-depth macros for the DA_VINCI memory interface
`ifndef PRJ_DEFINITION_V
`define PRJ_DEFINITION_V

`define ADDRESS_INDEX_LIMIT 25
`define DATA_INDEX_LIMIT    31
`define TRACE_DEPTH         16
`define TRACE_TS_WIDTH      16

`endif

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO with a registered head word that holds its last value when drained
module trace_fifo #(
  parameter int WIDTH = 74,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [PW-1:0]    rd_next;
  logic             pop_en;
  logic             push_en;

  assign full  = (count_q == FULL_CNT);
  assign empty = ~valid_q;
  assign valid = valid_q;
  assign count = count_q;
  assign rdata = head_q;

  always_comb begin
    rd_next = rd_ptr_q + PW'(1);
    pop_en  = pop & valid_q & ~clr;
    push_en = push & (~full | pop_en) & ~clr;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_d = rd_next;
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // The head register is loaded from whichever entry becomes the new head this edge.
      if (pop_en) begin
        if (count_q > CW'(1)) head_d = mem_q[rd_next];
        else if (push_en)     head_d = wdata;
      end else if (push_en && !valid_q) begin
        head_d = wdata;
      end
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/mem_access_tracer.sv
// rtl/mem_access_tracer.sv - passive tracer of windowed CPU write transactions into a drainable FIFO
`include "prj_definition.v"

module mem_access_tracer
  import mem_access_tracer_pkg::*;
#(
  parameter int                DEPTH    = `TRACE_DEPTH,
  parameter int                TS_WIDTH = `TRACE_TS_WIDTH,
  parameter logic [ADDR_W-1:0] WIN_LO   = 26'h0000000,
  parameter logic [ADDR_W-1:0] WIN_HI   = 26'h3FFFFFF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ADDR_W-1:0]        BUS_ADDR,
  input  logic [DATA_W-1:0]        BUS_WDATA,
  input  logic                     BUS_READ,
  input  logic                     BUS_WRITE,
  input  logic                     CLR,
  output logic                     TRC_VALID,
  input  logic                     TRC_READY,
  output logic [ADDR_W-1:0]        TRC_ADDR,
  output logic [DATA_W-1:0]        TRC_DATA,
  output logic [TS_WIDTH-1:0]      TRC_TS,
  output logic [$clog2(DEPTH):0]   TRC_COUNT,
  output logic                     OVERFLOW,
  output logic                     PROTO_ERR,
  output logic [DROP_W-1:0]        DROP_CNT
);

  localparam int EW = ADDR_W + DATA_W + TS_WIDTH;

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                wr_prev_q, wr_prev_d;
  logic                overflow_q, overflow_d;
  logic                proto_err_q, proto_err_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic                wr_edge;
  logic                write_event;
  logic                pop_req;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [EW-1:0]       fifo_rdata;

  always_comb begin
    wr_edge     = BUS_WRITE & ~BUS_READ & ~wr_prev_q;
    write_event = wr_edge & in_window(BUS_ADDR, WIN_LO, WIN_HI);
    pop_req     = TRC_READY & ~fifo_empty;
    drop        = write_event & fifo_full & ~pop_req & ~CLR;
  end

  always_comb begin
    ts_d        = ts_q;
    overflow_d  = overflow_q;
    proto_err_d = proto_err_q;
    drop_cnt_d  = drop_cnt_q;
    wr_prev_d   = BUS_WRITE;
    if (CLR) begin
      ts_d        = '0;
      overflow_d  = 1'b0;
      proto_err_d = 1'b0;
      drop_cnt_d  = '0;
    end else begin
      ts_d = ts_q + TS_WIDTH'(1);
      if (BUS_READ && BUS_WRITE) proto_err_d = 1'b1;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ts_q        <= '0;
      wr_prev_q   <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      ts_q        <= ts_d;
      wr_prev_q   <= wr_prev_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .clr   (CLR),
    .push  (write_event & ~drop),
    .pop   (pop_req),
    .wdata ({BUS_ADDR, BUS_WDATA, ts_q}),
    .rdata (fifo_rdata),
    .count (TRC_COUNT),
    .valid (TRC_VALID),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign TRC_ADDR  = fifo_rdata[EW-1 -: ADDR_W];
  assign TRC_DATA  = fifo_rdata[TS_WIDTH +: DATA_W];
  assign TRC_TS    = fifo_rdata[TS_WIDTH-1:0];
  assign OVERFLOW  = overflow_q;
  assign PROTO_ERR = proto_err_q;
  assign DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_mem_access_tracer.sv
// tb/tb_mem_access_tracer.sv - directed and randomized checks of mem_access_tracer against a queue model
module tb_mem_access_tracer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [25:0] addr;
  logic [31:0] wdata;
  logic        rd, wr, clr, ready, w_ready;

  logic        valid, ovf, perr;
  logic [25:0] t_addr;
  logic [31:0] t_data;
  logic [15:0] t_ts;
  logic [4:0]  t_cnt;
  logic [7:0]  drop;

  logic        w_valid, w_ovf, w_perr;
  logic [25:0] w_addr;
  logic [31:0] w_data;
  logic [15:0] w_ts;
  logic [4:0]  w_cnt;
  logic [7:0]  w_drop;

  always #5 CLK = ~CLK;

  mem_access_tracer dut (
    .CLK(CLK), .RST(RST), .BUS_ADDR(addr), .BUS_WDATA(wdata), .BUS_READ(rd), .BUS_WRITE(wr),
    .CLR(clr), .TRC_VALID(valid), .TRC_READY(ready), .TRC_ADDR(t_addr), .TRC_DATA(t_data),
    .TRC_TS(t_ts), .TRC_COUNT(t_cnt), .OVERFLOW(ovf), .PROTO_ERR(perr), .DROP_CNT(drop)
  );

  mem_access_tracer #(.WIN_LO(26'h3FFFFF0)) dut_w (
    .CLK(CLK), .RST(RST), .BUS_ADDR(addr), .BUS_WDATA(wdata), .BUS_READ(rd), .BUS_WRITE(wr),
    .CLR(clr), .TRC_VALID(w_valid), .TRC_READY(w_ready), .TRC_ADDR(w_addr), .TRC_DATA(w_data),
    .TRC_TS(w_ts), .TRC_COUNT(w_cnt), .OVERFLOW(w_ovf), .PROTO_ERR(w_perr), .DROP_CNT(w_drop)
  );

  typedef struct {
    logic [25:0] a;
    logic [31:0] d;
    logic [15:0] t;
  } ent_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t mq[$];
  ent_t m_last;
  int   m_ts;
  bit   m_prev, m_ovf, m_perr;
  int   m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '{26'h0, 32'h0, 16'h0};
    m_ts   = 0;
    m_prev = 0;
    m_ovf  = 0;
    m_perr = 0;
    m_drop = 0;
  endtask

  // One rising edge of the reference behaviour, using the inputs currently driven.
  task automatic model_edge();
    bit pop, ev, was_full;
    if (clr) begin
      model_reset();
    end else begin
      was_full = (mq.size() == 16);
      pop      = (mq.size() != 0) && ready;
      ev       = wr && !rd && !m_prev;
      if (rd && wr) m_perr = 1;
      if (pop) void'(mq.pop_front());
      if (ev) begin
        if (!was_full || pop) mq.push_back('{addr, wdata, 16'(m_ts)});
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      m_ts = (m_ts + 1) % 65536;
    end
    m_prev = wr;
    if (mq.size() != 0) m_last = mq[0];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(valid), 64'(mq.size() != 0));
    chk({tag, ".count"}, 64'(t_cnt), 64'(mq.size()));
    chk({tag, ".ovf"},   64'(ovf),   64'(m_ovf));
    chk({tag, ".perr"},  64'(perr),  64'(m_perr));
    chk({tag, ".drop"},  64'(drop),  64'(m_drop));
    chk({tag, ".addr"},  64'(t_addr), 64'(m_last.a));
    chk({tag, ".data"},  64'(t_data), 64'(m_last.d));
    chk({tag, ".ts"},    64'(t_ts),   64'(m_last.t));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic write_pulse(input logic [25:0] a, input logic [31:0] d, input string tag);
    addr = a; wdata = d; wr = 1'b1;
    tick(tag);
    wr = 1'b0;
    tick(tag);
  endtask

  initial begin
    RST = 1'b1; addr = '0; wdata = '0; rd = 0; wr = 0; clr = 0; ready = 0; w_ready = 1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Single write with timestamp 7 at the capturing edge.
    clr = 1; tick("clr0"); clr = 0;
    repeat (7) tick("ts_run");
    addr = 26'h1000000; wdata = 32'h1; wr = 1;
    tick("single");
    chk("single.valid", 64'(valid), 64'd1);
    chk("single.addr", 64'(t_addr), 64'h1000000);
    chk("single.data", 64'(t_data), 64'h1);
    chk("single.ts", 64'(t_ts), 64'd7);
    chk("single.count", 64'(t_cnt), 64'd1);
    wr = 0; tick("single");
    ready = 1; tick("single_drain"); ready = 0;

    // Held write strobe followed by a read counts once.
    clr = 1; tick("clr1"); clr = 0;
    addr = 26'h0000ABC; wdata = 32'hDEAD0001; wr = 1;
    repeat (4) tick("held");
    wr = 0; tick("held");
    rd = 1; tick("held_rd"); rd = 0; tick("held");
    chk("held.count", 64'(t_cnt), 64'd1);

    // Window filter on the second instance.
    clr = 1; tick("clr2"); clr = 0;
    addr = 26'h3FFFFF5; wdata = 32'h55; wr = 1; tick("win");
    chk("win.hit_valid", 64'(w_valid), 64'd1);
    chk("win.hit_addr", 64'(w_addr), 64'h3FFFFF5);
    wr = 0; tick("win");
    addr = 26'h0000010; wdata = 32'h66; wr = 1; tick("win");
    chk("win.miss_valid", 64'(w_valid), 64'd0);
    wr = 0; tick("win");
    chk("win.dut_count", 64'(t_cnt), 64'd2);

    // Overflow: 18 events into 16 slots.
    clr = 1; tick("clr3"); clr = 0; ready = 0;
    for (int i = 0; i < 18; i++) write_pulse(26'(i * 4), 32'(100 + i), "ovf_fill");
    chk("ovf.count", 64'(t_cnt), 64'd16);
    chk("ovf.flag", 64'(ovf), 64'd1);
    chk("ovf.drop", 64'(drop), 64'd2);
    ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf.order", 64'(t_data), 64'(100 + i));
      tick("ovf_drain");
    end
    chk("ovf.empty", 64'(valid), 64'd0);
    ready = 0;

    // Push and pop together while full.
    clr = 1; tick("clr4"); clr = 0;
    for (int i = 0; i < 16; i++) write_pulse(26'(i), 32'(200 + i), "full_fill");
    ready = 1; addr = 26'h0000FFF; wdata = 32'hCAFE; wr = 1;
    tick("full_pp");
    chk("full_pp.count", 64'(t_cnt), 64'd16);
    chk("full_pp.drop", 64'(drop), 64'd0);
    wr = 0;
    for (int i = 0; i < 16; i++) begin
      chk("full_pp.order", 64'(t_data), (i < 15) ? 64'(201 + i) : 64'hCAFE);
      tick("full_drain");
    end
    ready = 0;

    // Protocol error, then clear restarts the timestamp.
    rd = 1; wr = 1; tick("perr");
    chk("perr.flag", 64'(perr), 64'd1);
    chk("perr.count", 64'(t_cnt), 64'd0);
    rd = 0; wr = 0; tick("perr");
    clr = 1; tick("clr5"); clr = 0;
    chk("clr.perr", 64'(perr), 64'd0);
    chk("clr.ovf", 64'(ovf), 64'd0);
    chk("clr.drop", 64'(drop), 64'd0);
    chk("clr.count", 64'(t_cnt), 64'd0);
    addr = 26'h0000123; wdata = 32'h77; wr = 1; tick("clr_ts");
    chk("clr.ts_zero", 64'(t_ts), 64'd0);
    wr = 0; tick("clr_ts");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      addr  = 26'($urandom);
      wdata = $urandom;
      wr    = ($urandom_range(0, 2) == 0);
      rd    = ($urandom_range(0, 7) == 0);
      ready = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 59) == 0);
      tick("rand");
    end
    rd = 0; wr = 0; clr = 0; ready = 0;
    tick("rand_end");

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 4; i++) write_pulse(26'(i + 8), 32'(300 + i), "rst_fill");
    ready = 1; tick("rst_drain");
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst.valid", 64'(valid), 64'd0);
    chk("rst.count", 64'(t_cnt), 64'd0);
    chk("rst.ovf", 64'(ovf), 64'd0);
    chk("rst.drop", 64'(drop), 64'd0);
    chk("rst.addr", 64'(t_addr), 64'd0);
    @(negedge CLK);
    RST = 1'b0; ready = 0;
    write_pulse(26'h0000040, 32'h99, "post_rst");
    chk("post_rst.ts", 64'(t_ts), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
